// File: rtl/issue_unit_pkg.sv
// Shared issue-stage types: unit latencies, CDB owner encoding and
// the reservation-station queue entry layout.
package issue_unit_pkg;

  localparam int INT_LAT_D  = 1;
  localparam int LDST_LAT_D = 2;
  localparam int MULT_LAT_D = 4;
  localparam int DIV_LAT_D  = 7;

  typedef enum logic [1:0] {
    OWN_INT  = 2'd0,
    OWN_LDST = 2'd1,
    OWN_MULT = 2'd2,
    OWN_DIV  = 2'd3
  } owner_e;

  typedef struct packed {
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] op_a;
    logic        a_vld;
    logic [31:0] op_b;
    logic        b_vld;
  } iq_entry_t;

  function automatic logic iq_ready(input iq_entry_t e);
    return e.valid & e.a_vld & e.b_vld;
  endfunction

endpackage

// File: rtl/cdb_reservation_sr.sv
// CDB reservation shift register: one bit plus owner per future slot,
// shifting toward slot 0 every cycle.
module cdb_reservation_sr
  import issue_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IW-1:0]    set_idx,
  input  owner_e           set_owner,
  output logic [DEPTH-1:0] res,
  output owner_e           owner0
);

  owner_e own_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      for (int k = 0; k < DEPTH; k++)
        own_q[k] <= OWN_INT;
    end else begin
      for (int k = 0; k < DEPTH-1; k++) begin
        res[k]   <= res[k+1];
        own_q[k] <= own_q[k+1];
      end
      res[DEPTH-1]   <= 1'b0;
      own_q[DEPTH-1] <= OWN_INT;
      if (set_en) begin
        res[set_idx]   <= 1'b1;
        own_q[set_idx] <= set_owner;
      end
    end
  end

  assign owner0 = own_q[0];

endmodule

// File: rtl/issue_unit.sv
// Issue arbiter: grants one functional unit per cycle so that no two
// results ever collide on the common data bus.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int INT_LAT  = INT_LAT_D,
  parameter int LDST_LAT = LDST_LAT_D,
  parameter int MULT_LAT = MULT_LAT_D,
  parameter int DIV_LAT  = DIV_LAT_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready_int,
  input  logic       ready_ldst,
  input  logic       ready_mult,
  input  logic       ready_div,
  input  logic       flush,
  output logic       issue_int,
  output logic       issue_ldst,
  output logic       issue_mult,
  output logic       issue_div,
  output logic       cdb_valid,
  output logic [1:0] cdb_owner,
  output logic       div_busy
);

  localparam int DEPTH = DIV_LAT + 1;
  localparam int IW    = $clog2(DEPTH);
  localparam int DCW   = $clog2(DIV_LAT + 1);
  localparam logic RR_INT  = 1'b0;
  localparam logic RR_LDST = 1'b1;

  logic [DEPTH-1:0] res;
  owner_e           owner0;
  logic [DCW-1:0]   div_cnt;
  logic             rr_last;
  logic             open;
  logic             e_int, e_ldst, e_mult, e_div;
  logic             set_en;
  logic [IW-1:0]    set_idx;
  owner_e           set_owner;
  logic             unused_res;

  cdb_reservation_sr #(.DEPTH(DEPTH)) u_sr (
    .clk       (clk),
    .rst       (rst),
    .set_en    (set_en),
    .set_idx   (set_idx),
    .set_owner (set_owner),
    .res       (res),
    .owner0    (owner0)
  );

  // Eligibility looks at the pre-shift vector.
  assign open   = !rst && !flush;
  assign e_int  = open && ready_int  && !res[INT_LAT];
  assign e_ldst = open && ready_ldst && !res[LDST_LAT];
  assign e_mult = open && ready_mult && !res[MULT_LAT];
  assign e_div  = open && ready_div  && !res[DIV_LAT]
                  && (div_cnt == '0);

  assign issue_div  = e_div;
  assign issue_mult = e_mult && !e_div;
  assign issue_int  = e_int && !e_div && !e_mult
                      && (!e_ldst || rr_last == RR_LDST);
  assign issue_ldst = e_ldst && !e_div && !e_mult
                      && (!e_int || rr_last == RR_INT);

  assign set_en = issue_int | issue_ldst | issue_mult | issue_div;

  always_comb begin
    set_idx   = '0;
    set_owner = OWN_INT;
    unique case (1'b1)
      issue_div: begin
        set_idx   = IW'(DIV_LAT - 1);
        set_owner = OWN_DIV;
      end
      issue_mult: begin
        set_idx   = IW'(MULT_LAT - 1);
        set_owner = OWN_MULT;
      end
      issue_int: begin
        set_idx   = IW'(INT_LAT - 1);
        set_owner = OWN_INT;
      end
      issue_ldst: begin
        set_idx   = IW'(LDST_LAT - 1);
        set_owner = OWN_LDST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      div_cnt <= '0;
    else if (issue_div)
      div_cnt <= DCW'(DIV_LAT - 1);
    else if (div_cnt != '0)
      div_cnt <= div_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_last <= RR_LDST;
    else if (issue_int)
      rr_last <= RR_INT;
    else if (issue_ldst)
      rr_last <= RR_LDST;
  end

  assign div_busy   = (div_cnt != '0);
  assign cdb_valid  = res[0];
  assign cdb_owner  = res[0] ? owner0 : OWN_INT;
  assign unused_res = ^res;

endmodule

// File: tb/tb_issue_unit.sv
// Directed-vector bench for issue_unit; expectations queued by the
// driver and popped by an independent monitor each cycle.
module tb_issue_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready_int = 1'b0, ready_ldst = 1'b0;
  logic       ready_mult = 1'b0, ready_div = 1'b0;
  logic       flush = 1'b0;
  logic       issue_int, issue_ldst, issue_mult, issue_div;
  logic       cdb_valid;
  logic [1:0] cdb_owner;
  logic       div_busy;

  issue_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ready_int  (ready_int),
    .ready_ldst (ready_ldst),
    .ready_mult (ready_mult),
    .ready_div  (ready_div),
    .flush      (flush),
    .issue_int  (issue_int),
    .issue_ldst (issue_ldst),
    .issue_mult (issue_mult),
    .issue_div  (issue_div),
    .cdb_valid  (cdb_valid),
    .cdb_owner  (cdb_owner),
    .div_busy   (div_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] iss;
    logic       cv;
    logic [1:0] own;
    logic       busy;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  // rdy / iss bit order: {div, mult, ldst, int}
  task automatic v(input logic [3:0] rdy, input logic fl,
                   input logic rs, input logic [3:0] iss,
                   input logic cv, input logic [1:0] own,
                   input logic busy);
    exp_t e;
    @(posedge clk);
    #1;
    {ready_div, ready_mult, ready_ldst, ready_int} = rdy;
    flush = fl;
    rst   = rs;
    e.iss  = iss;
    e.cv   = cv;
    e.own  = own;
    e.busy = busy;
    e.id   = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int id,
                     input logic [3:0] act, input logic [3:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, id, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] iss;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      iss = {issue_div, issue_mult, issue_ldst, issue_int};
      chk("issue", e.id, iss, e.iss);
      chk("onehot", e.id, {3'b0, ($countones(iss) <= 1)}, 4'd1);
      chk("cdb_valid", e.id, {3'b0, cdb_valid}, {3'b0, e.cv});
      chk("cdb_owner", e.id, {2'b0, cdb_owner}, {2'b0, e.own});
      chk("div_busy", e.id, {3'b0, div_busy}, {3'b0, e.busy});
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    // reset gates grants even with everything ready
    v(4'b1111, 0, 1, 4'b0000, 0, 0, 0);
    // round robin: int first after reset, then ldst
    v(4'b0011, 0, 0, 4'b0001, 0, 0, 0);
    v(4'b0011, 0, 0, 4'b0010, 1, 0, 0);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    v(4'b0011, 0, 0, 4'b0001, 1, 1, 0);
    v(4'b0011, 0, 0, 4'b0010, 1, 0, 0);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    v(4'b0000, 0, 0, 4'b0000, 1, 1, 0);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    // reset, then int-only stream
    v(4'b0000, 0, 1, 4'b0000, 0, 0, 0);
    v(4'b0001, 0, 0, 4'b0001, 0, 0, 0);
    v(4'b0001, 0, 0, 4'b0001, 1, 0, 0);
    v(4'b0001, 0, 0, 4'b0001, 1, 0, 0);
    v(4'b0000, 0, 0, 4'b0000, 1, 0, 0);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    // priority: div then mult; mult result lands first
    v(4'b1100, 0, 0, 4'b1000, 0, 0, 0);
    v(4'b1100, 0, 0, 4'b0100, 0, 0, 1);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 1);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 1);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 1);
    v(4'b0000, 0, 0, 4'b0000, 1, 2, 1);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 1);
    v(4'b0000, 0, 0, 4'b0000, 1, 3, 0);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    // slot conflict: ldst blocked by mult reservation
    v(4'b0100, 0, 0, 4'b0100, 0, 0, 0);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    v(4'b0010, 0, 0, 4'b0000, 0, 0, 0);
    v(4'b0010, 0, 0, 4'b0010, 0, 0, 0);
    v(4'b0000, 0, 0, 4'b0000, 1, 2, 0);
    v(4'b0000, 0, 0, 4'b0000, 1, 1, 0);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    // divider spacing
    v(4'b1000, 0, 0, 4'b1000, 0, 0, 0);
    repeat (6) v(4'b1000, 0, 0, 4'b0000, 0, 0, 1);
    v(4'b1000, 0, 0, 4'b1000, 1, 3, 0);
    repeat (6) v(4'b1000, 0, 0, 4'b0000, 0, 0, 1);
    v(4'b1000, 0, 0, 4'b1000, 1, 3, 0);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 1);
    // flush keeps in-flight mult result
    v(4'b0100, 0, 0, 4'b0100, 0, 0, 1);
    v(4'b1111, 1, 0, 4'b0000, 0, 0, 1);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 1);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 1);
    v(4'b0000, 0, 0, 4'b0000, 1, 2, 1);
    v(4'b0000, 0, 0, 4'b0000, 1, 3, 0);
    // reset mid-divide drops reservation and count
    v(4'b0001, 0, 0, 4'b0001, 0, 0, 0);
    v(4'b1000, 0, 0, 4'b1000, 1, 0, 0);
    v(4'b0000, 0, 0, 4'b0000, 0, 0, 1);
    v(4'b1111, 0, 1, 4'b0000, 0, 0, 1);
    repeat (6) v(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    v(4'b0011, 0, 0, 4'b0001, 0, 0, 0);
    v(4'b0000, 0, 0, 4'b0000, 1, 0, 0);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++)
      @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
